// File: rtl/lap_stopwatch.sv
// Stopwatch with prescaled tick counter and a circular lap memory holding the
// newest MEM_DEPTH laps (split or delta per lap), browsable while stopped.
module lap_stopwatch #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int TICK_HZ    = 10,
  parameter int BIT_DEPTH  = 16,
  parameter int MEM_DEPTH  = 8,
  parameter int ADDR_W     = 3,
  parameter int PRE_W      = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_stop,
  input  logic                 lap,
  input  logic                 clear,
  input  logic                 show_next,
  input  logic                 show_prev,
  input  logic                 delta_mode,
  output logic                 running,
  output logic [BIT_DEPTH-1:0] elapsed,
  output logic [BIT_DEPTH-1:0] last_lap,
  output logic [ADDR_W:0]      lap_count,
  output logic [ADDR_W-1:0]    show_idx,
  output logic [BIT_DEPTH-1:0] show_value,
  output logic                 mem_full,
  output logic                 overflow
);
  localparam int                   DIV      = CLOCK_FREQ / TICK_HZ;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [BIT_DEPTH-1:0] EL_MAX   = '1;
  localparam logic [ADDR_W:0]      FULL     = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                 state_q, state_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [BIT_DEPTH-1:0]   elapsed_q, elapsed_d;
  logic [BIT_DEPTH-1:0]   last_lap_q, last_lap_d;
  logic [BIT_DEPTH-1:0]   last_split_q, last_split_d;
  logic [ADDR_W:0]        lap_count_q, lap_count_d;
  logic [ADDR_W-1:0]      show_idx_q, show_idx_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      oldest_ptr_q, oldest_ptr_d;
  logic                   overflow_q, overflow_d;
  logic [BIT_DEPTH-1:0]   mem_q [MEM_DEPTH];
  logic                   mem_we;
  logic                   tick;
  logic [BIT_DEPTH-1:0]   lap_v;
  logic [ADDR_W-1:0]      rd_addr;

  assign tick  = (state_q == RUN) && (pre_q == PRE_LAST);
  assign lap_v = delta_mode ? (elapsed_q - last_split_q) : elapsed_q;

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    elapsed_d    = elapsed_q;
    last_lap_d   = last_lap_q;
    last_split_d = last_split_q;
    lap_count_d  = lap_count_q;
    show_idx_d   = show_idx_q;
    wr_ptr_d     = wr_ptr_q;
    oldest_ptr_d = oldest_ptr_q;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;

    // Time base runs regardless of which pulse (if any) wins this cycle.
    if (state_q == RUN) pre_d = tick ? '0 : pre_q + 1'b1;
    if (tick) begin
      if (elapsed_q == EL_MAX) overflow_d = 1'b1;
      else                     elapsed_d  = elapsed_q + 1'b1;
    end

    if (start_stop) begin
      case (state_q)
        RUN: begin
          state_d    = PAUSE;
          show_idx_d = '0;
        end
        IDLE, PAUSE: state_d = RUN;
        default:     state_d = IDLE;
      endcase
    end else if (lap) begin
      if (state_q == RUN) begin
        mem_we       = 1'b1;
        last_lap_d   = lap_v;
        last_split_d = elapsed_q;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        if (lap_count_q != FULL) lap_count_d  = lap_count_q + 1'b1;
        else                     oldest_ptr_d = oldest_ptr_q + 1'b1;
      end
    end else if (clear) begin
      if (state_q != RUN) begin
        state_d      = IDLE;
        pre_d        = '0;
        elapsed_d    = '0;
        last_lap_d   = '0;
        last_split_d = '0;
        lap_count_d  = '0;
        show_idx_d   = '0;
        wr_ptr_d     = '0;
        oldest_ptr_d = '0;
        overflow_d   = 1'b0;
      end
    end else if (show_next) begin
      if (state_q != RUN && lap_count_q != '0)
        show_idx_d = ({1'b0, show_idx_q} == lap_count_q - 1'b1) ? '0 : show_idx_q + 1'b1;
    end else if (show_prev) begin
      if (state_q != RUN && lap_count_q != '0)
        show_idx_d = (show_idx_q == '0) ? ADDR_W'(lap_count_q - 1'b1) : show_idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      elapsed_q    <= '0;
      last_lap_q   <= '0;
      last_split_q <= '0;
      lap_count_q  <= '0;
      show_idx_q   <= '0;
      wr_ptr_q     <= '0;
      oldest_ptr_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      elapsed_q    <= elapsed_d;
      last_lap_q   <= last_lap_d;
      last_split_q <= last_split_d;
      lap_count_q  <= lap_count_d;
      show_idx_q   <= show_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      oldest_ptr_q <= oldest_ptr_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= lap_v;
    end
  end

  // Browse index is relative to the oldest entry; pointer math wraps at MEM_DEPTH.
  assign rd_addr    = oldest_ptr_q + show_idx_q;
  assign show_value = (lap_count_q == '0) ? '0 : mem_q[rd_addr];

  assign running   = (state_q == RUN);
  assign mem_full  = (lap_count_q == FULL);
  assign elapsed   = elapsed_q;
  assign last_lap  = last_lap_q;
  assign lap_count = lap_count_q;
  assign show_idx  = show_idx_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch: DIV=10, 8-bit values, 4-entry lap memory.
module tb_lap_stopwatch;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic       show_next = 1'b0, show_prev = 1'b0, delta_mode = 1'b0;
  logic       running, mem_full, overflow;
  logic [7:0] elapsed, last_lap, show_value;
  logic [2:0] lap_count;
  logic [1:0] show_idx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [4:0] P_SS = 5'b10000;
  localparam logic [4:0] P_LP = 5'b01000;
  localparam logic [4:0] P_CL = 5'b00100;
  localparam logic [4:0] P_NX = 5'b00010;
  localparam logic [4:0] P_PV = 5'b00001;

  lap_stopwatch #(
    .CLOCK_FREQ(100), .TICK_HZ(10), .BIT_DEPTH(8),
    .MEM_DEPTH(4), .ADDR_W(2), .PRE_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap),
    .clear(clear), .show_next(show_next), .show_prev(show_prev),
    .delta_mode(delta_mode), .running(running), .elapsed(elapsed),
    .last_lap(last_lap), .lap_count(lap_count), .show_idx(show_idx),
    .show_value(show_value), .mem_full(mem_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step1();
  endtask

  // Drive pulse set p so that it is sampled on edge number e.
  task automatic hit(input logic [4:0] p, input int e);
    run_to(e - 1);
    {start_stop, lap, clear, show_next, show_prev} = p;
    step1();
    {start_stop, lap, clear, show_next, show_prev} = 5'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step1();
    step1();
    reset = 1'b0;
  endtask

  // Start from IDLE; edge numbering restarts at the start edge.
  task automatic do_start();
    hit(P_SS, cyc + 1);
    cyc = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".running"},   32'(running),    0);
    chk({tag, ".elapsed"},   32'(elapsed),    0);
    chk({tag, ".last_lap"},  32'(last_lap),   0);
    chk({tag, ".lap_count"}, 32'(lap_count),  0);
    chk({tag, ".show_idx"},  32'(show_idx),   0);
    chk({tag, ".show_val"},  32'(show_value), 0);
    chk({tag, ".mem_full"},  32'(mem_full),   0);
    chk({tag, ".overflow"},  32'(overflow),   0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_zero("rst");

    // 1: pause holds elapsed, prescaler resumes mid-period
    do_start();
    chk("t1.run", 32'(running), 1);
    hit(P_SS, 36);
    chk("t1.el_pause", 32'(elapsed), 3);
    chk("t1.run_off", 32'(running), 0);
    run_to(86);
    chk("t1.el_held", 32'(elapsed), 3);
    hit(P_SS, 87);
    run_to(90);
    chk("t1.el_pre", 32'(elapsed), 3);
    run_to(94);
    chk("t1.el_resume", 32'(elapsed), 4);

    // 2: split laps 2, 5, 9 and browsing
    do_reset();
    do_start();
    hit(P_LP, 25);
    chk("t2.ll1", 32'(last_lap), 2);
    hit(P_LP, 55);
    hit(P_LP, 95);
    chk("t2.cnt", 32'(lap_count), 3);
    chk("t2.ll3", 32'(last_lap), 9);
    hit(P_SS, 96);
    chk("t2.idx0", 32'(show_idx), 0);
    chk("t2.sv0", 32'(show_value), 2);
    hit(P_NX, cyc + 1);
    chk("t2.nx1", 32'(show_value), 5);
    hit(P_NX, cyc + 1);
    chk("t2.nx2", 32'(show_value), 9);
    hit(P_NX, cyc + 1);
    chk("t2.nx3", 32'(show_value), 2);
    chk("t2.nx3_idx", 32'(show_idx), 0);
    hit(P_PV, cyc + 1);
    chk("t2.pv_idx", 32'(show_idx), 2);
    chk("t2.pv", 32'(show_value), 9);

    // 3: delta laps at 4, 10, 11
    do_reset();
    delta_mode = 1'b1;
    do_start();
    hit(P_LP, 45);
    chk("t3.ll1", 32'(last_lap), 4);
    hit(P_LP, 105);
    chk("t3.ll2", 32'(last_lap), 6);
    hit(P_LP, 115);
    chk("t3.ll3", 32'(last_lap), 1);
    delta_mode = 1'b0;
    hit(P_SS, 116);
    chk("t3.m0", 32'(show_value), 4);
    hit(P_NX, cyc + 1);
    chk("t3.m1", 32'(show_value), 6);
    hit(P_NX, cyc + 1);
    chk("t3.m2", 32'(show_value), 1);

    // 4: wrap-around keeps the newest four laps
    do_reset();
    do_start();
    for (int i = 1; i <= 6; i++) begin
      hit(P_LP, 10 * i + 5);
      if (i == 3) begin
        chk("t4.cnt3", 32'(lap_count), 3);
        chk("t4.nfull", 32'(mem_full), 0);
      end
    end
    chk("t4.cnt", 32'(lap_count), 4);
    chk("t4.full", 32'(mem_full), 1);
    chk("t4.ll", 32'(last_lap), 6);
    hit(P_SS, cyc + 1);
    chk("t4.idx0", 32'(show_idx), 0);
    chk("t4.sv0", 32'(show_value), 3);
    for (int i = 1; i <= 4; i++) begin
      hit(P_NX, cyc + 1);
      chk("t4.browse", 32'(show_value), (i == 4) ? 3 : 3 + i);
    end

    // 5: saturation, overflow, clear rules
    do_reset();
    do_start();
    run_to(2559);
    chk("t5.el_max", 32'(elapsed), 255);
    chk("t5.ovf_pre", 32'(overflow), 0);
    hit(P_LP, 2560);
    chk("t5.el_sat", 32'(elapsed), 255);
    chk("t5.ovf", 32'(overflow), 1);
    chk("t5.ll", 32'(last_lap), 255);
    hit(P_CL, 2561);
    chk("t5.clr_run_el", 32'(elapsed), 255);
    chk("t5.clr_run_cnt", 32'(lap_count), 1);
    chk("t5.clr_run_r", 32'(running), 1);
    run_to(2600);
    chk("t5.ovf_held", 32'(overflow), 1);
    chk("t5.el_held", 32'(elapsed), 255);
    hit(P_SS, 2601);
    hit(P_CL, 2602);
    chk_zero("t5.clr");

    // 6: coincident pulses, ignored lap, tick+lap, reset mid-run
    do_reset();
    do_start();
    hit(P_SS | P_LP, 26);
    chk("t6.paused", 32'(running), 0);
    chk("t6.nolap", 32'(lap_count), 0);
    hit(P_LP, 27);
    chk("t6.pause_lap", 32'(lap_count), 0);
    hit(P_SS, 28);
    run_to(31);
    chk("t6.el2", 32'(elapsed), 2);
    hit(P_LP, 32);
    chk("t6.el3", 32'(elapsed), 3);
    chk("t6.ll_pre", 32'(last_lap), 2);
    chk("t6.cnt", 32'(lap_count), 1);
    run_to(34);
    reset = 1'b1;
    step1();
    chk_zero("t6.rst");
    reset = 1'b0;
    step1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
